// File: rtl/touch_tap_decoder_pkg.sv
// ---------------------------------------------------------------------------
// touch_tap_decoder_pkg
//   Shared constants and types for the touch tap decoder slice.
//   - Hole grid geometry defaults (also used by the LCD renderer)
//   - Debounce/release times in clock cycles (50 MHz domain)
//   - State enums for the decoder FSM and the cell locator
//   - hole_index(): row/col to linear hole number
// ---------------------------------------------------------------------------
package touch_tap_decoder_pkg;

    // Mole grid: 5 columns x 4 rows = 20 holes
    localparam int unsigned NUM_HOLES = 20;
    localparam int unsigned HOLE_W    = 5;

    // Touch coordinates are unsigned 16-bit pixels
    localparam int unsigned COORD_W   = 16;

    // Wide enough to hold col==COLS / row==ROWS (the overflow markers)
    localparam int unsigned IDX_W     = 3;

    // Grid geometry defaults (pixels)
    localparam int unsigned GRID_X0_DEF = 80;
    localparam int unsigned GRID_Y0_DEF = 120;
    localparam int unsigned CELL_W_DEF  = 128;
    localparam int unsigned CELL_H_DEF  = 96;
    localparam int unsigned COLS_DEF    = 5;
    localparam int unsigned ROWS_DEF    = 4;

    // Debounce timing: 10 ms press, 5 ms release at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned RELEASE_CYCLES_DEF  = 250000;
    localparam int unsigned CNT_W_DEF           = 20;

    // Decoder FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_LOCATE,
        ST_EMIT,
        ST_HELD
    } tap_state_e;

    // Cell locator phases
    typedef enum logic [1:0] {
        LOC_IDLE,
        LOC_INIT,
        LOC_STEP
    } loc_phase_e;

    // Linear hole number row*cols+col; a constant multiply, no divider involved
    function automatic logic [HOLE_W-1:0] hole_index(
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col,
        input int unsigned      cols
    );
        return HOLE_W'(row) * HOLE_W'(cols) + HOLE_W'(col);
    endfunction

endpackage

// File: rtl/touch_tap_decoder_if.sv
// ---------------------------------------------------------------------------
// touch_tap_decoder_if
//   Bundles the touch front-end stream and the decoded tap event.
//   master : touch front end / game side (drives en, touch stream, reads taps)
//   slave  : touch_tap_decoder
//   Signals:
//     en           decoding enable (high during game state)
//     touch_valid  finger down reported by the touch controller
//     tp_x_coord   touch x coordinate (16 bit)
//     tp_y_coord   touch y coordinate (16 bit)
//     tap_valid    one-cycle pulse per debounced press
//     tap_in_grid  tap lies inside a grid cell (held after the pulse)
//     tap_hole     hole index row*COLS+col, 0 when out of grid
//     tap_onehot   one-hot of tap_hole, zero outside the tap_valid cycle
//     touch_held   press accepted and not yet released
// ---------------------------------------------------------------------------
interface touch_tap_decoder_if;
    import touch_tap_decoder_pkg::*;

    logic                 en;
    logic                 touch_valid;
    logic [COORD_W-1:0]   tp_x_coord;
    logic [COORD_W-1:0]   tp_y_coord;
    logic                 tap_valid;
    logic                 tap_in_grid;
    logic [HOLE_W-1:0]    tap_hole;
    logic [NUM_HOLES-1:0] tap_onehot;
    logic                 touch_held;

    modport master (
        output en,
        output touch_valid,
        output tp_x_coord,
        output tp_y_coord,
        input  tap_valid,
        input  tap_in_grid,
        input  tap_hole,
        input  tap_onehot,
        input  touch_held
    );

    modport slave (
        input  en,
        input  touch_valid,
        input  tp_x_coord,
        input  tp_y_coord,
        output tap_valid,
        output tap_in_grid,
        output tap_hole,
        output tap_onehot,
        output touch_held
    );

endinterface

// File: rtl/touch_tap_decoder_locator.sv
// ---------------------------------------------------------------------------
// tap_cell_locator
//   Finds the grid cell of a touch point by repeated subtraction of the cell
//   size (no divider). start_i latches x_i/y_i; the next cycle checks the
//   grid origin, then each further cycle steps both axes by one cell while
//   possible. done_o is a combinational one-cycle strobe in the last cycle,
//   with col_o/row_o/in_grid_o valid alongside it.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     start_i      load coordinates and begin (overrides a run in progress)
//     x_i, y_i     touch coordinates
//     done_o       result valid this cycle
//     col_o/row_o  cell column/row (may equal COLS/ROWS on overflow)
//     in_grid_o    point lies inside a real cell
// ---------------------------------------------------------------------------
module tap_cell_locator
    import touch_tap_decoder_pkg::*;
#(
    parameter int unsigned GRID_X0 = GRID_X0_DEF,
    parameter int unsigned GRID_Y0 = GRID_Y0_DEF,
    parameter int unsigned CELL_W  = CELL_W_DEF,
    parameter int unsigned CELL_H  = CELL_H_DEF,
    parameter int unsigned COLS    = COLS_DEF,
    parameter int unsigned ROWS    = ROWS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               done_o,
    output logic [IDX_W-1:0]   col_o,
    output logic [IDX_W-1:0]   row_o,
    output logic               in_grid_o
);

    localparam logic [COORD_W-1:0] GRID_X0_C = COORD_W'(GRID_X0);
    localparam logic [COORD_W-1:0] GRID_Y0_C = COORD_W'(GRID_Y0);
    localparam logic [COORD_W-1:0] CELL_W_C  = COORD_W'(CELL_W);
    localparam logic [COORD_W-1:0] CELL_H_C  = COORD_W'(CELL_H);
    localparam logic [IDX_W-1:0]   COLS_C    = IDX_W'(COLS);
    localparam logic [IDX_W-1:0]   ROWS_C    = IDX_W'(ROWS);

    loc_phase_e         phase_q, phase_d;
    logic [COORD_W-1:0] xRem_q, xRem_d;
    logic [COORD_W-1:0] yRem_q, yRem_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic               stepX, stepY;

    // An axis stops either when the remainder is inside one cell or when the
    // index has run past the last column/row (overflow means out of grid).
    assign stepX = (xRem_q >= CELL_W_C) && (col_q < COLS_C);
    assign stepY = (yRem_q >= CELL_H_C) && (row_q < ROWS_C);

    assign col_o = col_q;
    assign row_o = row_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= LOC_IDLE;
            xRem_q  <= '0;
            yRem_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            phase_q <= phase_d;
            xRem_q  <= xRem_d;
            yRem_q  <= yRem_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // The remainder registers first hold the raw coordinates; the INIT
    // cycle rebases them to the grid origin so no separate latch is needed.
    always_comb begin
        phase_d   = phase_q;
        xRem_d    = xRem_q;
        yRem_d    = yRem_q;
        col_d     = col_q;
        row_d     = row_q;
        done_o    = 1'b0;
        in_grid_o = 1'b0;

        if (start_i) begin
            phase_d = LOC_INIT;
            xRem_d  = x_i;
            yRem_d  = y_i;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (phase_q)
                LOC_INIT: begin
                    if ((xRem_q < GRID_X0_C) || (yRem_q < GRID_Y0_C)) begin
                        done_o  = 1'b1;
                        phase_d = LOC_IDLE;
                    end else begin
                        xRem_d  = xRem_q - GRID_X0_C;
                        yRem_d  = yRem_q - GRID_Y0_C;
                        phase_d = LOC_STEP;
                    end
                end
                LOC_STEP: begin
                    if (!stepX && !stepY) begin
                        done_o    = 1'b1;
                        in_grid_o = (col_q < COLS_C) && (row_q < ROWS_C);
                        phase_d   = LOC_IDLE;
                    end else begin
                        if (stepX) begin
                            xRem_d = xRem_q - CELL_W_C;
                            col_d  = col_q + 1'b1;
                        end
                        if (stepY) begin
                            yRem_d = yRem_q - CELL_H_C;
                            row_d  = row_q + 1'b1;
                        end
                    end
                end
                default: begin
                    phase_d = LOC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/touch_tap_decoder.sv
// ---------------------------------------------------------------------------
// touch_tap_decoder
//   Turns the level-style touch stream into one debounced tap event per
//   finger press, mapped to a hole of the mole grid. Fires once per press
//   and re-arms only after a debounced release.
//   Ports:
//     clk    system clock (50 MHz)
//     rst_n  synchronous reset, active low
//     bus    touch_tap_decoder_if.slave (en, touch stream in; tap event out)
// ---------------------------------------------------------------------------
module touch_tap_decoder
    import touch_tap_decoder_pkg::*;
#(
    parameter int unsigned GRID_X0         = GRID_X0_DEF,
    parameter int unsigned GRID_Y0         = GRID_Y0_DEF,
    parameter int unsigned CELL_W          = CELL_W_DEF,
    parameter int unsigned CELL_H          = CELL_H_DEF,
    parameter int unsigned COLS            = COLS_DEF,
    parameter int unsigned ROWS            = ROWS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned RELEASE_CYCLES  = RELEASE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    touch_tap_decoder_if.slave   bus
);

    // DEBOUNCE enters with cnt=1 and exits when cnt already equals the
    // limit; HELD exits on the low sample that brings the count to the limit.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

    tap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tapValid_q, tapValid_d;
    logic              tapInGrid_q, tapInGrid_d;
    logic [HOLE_W-1:0] tapHole_q, tapHole_d;

    logic              locStart;
    logic              locDone;
    logic [IDX_W-1:0]  locCol;
    logic [IDX_W-1:0]  locRow;
    logic              locInGrid;

    // The locator latches the coordinates on the DEBOUNCE exit edge, which
    // only happens with touch_valid sampled high, so the latch always holds
    // a coordinate from a valid touch sample.
    tap_cell_locator #(
        .GRID_X0 (GRID_X0),
        .GRID_Y0 (GRID_Y0),
        .CELL_W  (CELL_W),
        .CELL_H  (CELL_H),
        .COLS    (COLS),
        .ROWS    (ROWS)
    ) u_locator (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (locStart),
        .x_i       (bus.tp_x_coord),
        .y_i       (bus.tp_y_coord),
        .done_o    (locDone),
        .col_o     (locCol),
        .row_o     (locRow),
        .in_grid_o (locInGrid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tapValid_q  <= 1'b0;
            tapInGrid_q <= 1'b0;
            tapHole_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tapValid_q  <= tapValid_d;
            tapInGrid_q <= tapInGrid_d;
            tapHole_q   <= tapHole_d;
        end
    end

    // Next state. en=0 wins over everything: back to IDLE, no pulse, and
    // the last hole/in_grid result stays visible to the game logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tapValid_d  = 1'b0;
        tapInGrid_d = tapInGrid_q;
        tapHole_d   = tapHole_q;
        locStart    = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.touch_valid) begin
                        state_d = ST_DEBOUNCE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!bus.touch_valid) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d  = ST_LOCATE;
                        cnt_d    = '0;
                        locStart = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOCATE: begin
                    if (locDone) begin
                        state_d     = ST_EMIT;
                        tapValid_d  = 1'b1;
                        tapInGrid_d = locInGrid;
                        tapHole_d   = locInGrid ? hole_index(locRow, locCol, COLS) : '0;
                    end
                end
                ST_EMIT: begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end
                ST_HELD: begin
                    if (bus.touch_valid) begin
                        cnt_d = '0;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.tap_valid   = tapValid_q;
    assign bus.tap_in_grid = tapInGrid_q;
    assign bus.tap_hole    = tapHole_q;
    // The mask only exists during the pulse so the game can AND it blindly
    assign bus.tap_onehot  = (tapValid_q && tapInGrid_q) ? (NUM_HOLES'(1) << tapHole_q) : '0;
    assign bus.touch_held  = (state_q == ST_EMIT) || (state_q == ST_HELD);

endmodule

// File: tb/tb_touch_tap_decoder.sv
// ---------------------------------------------------------------------------
// tb_touch_tap_decoder
//   Self-checking bench for touch_tap_decoder with short debounce/release
//   times. Directed table of taps plus hand-written corner sequences, then
//   randomized touch streams compared every cycle against a press-level
//   reference model.
// ---------------------------------------------------------------------------
module tb_touch_tap_decoder;
    import touch_tap_decoder_pkg::*;

    localparam int D   = 4;
    localparam int R   = 3;
    localparam int GX0 = 80;
    localparam int GY0 = 120;
    localparam int CW  = 128;
    localparam int CH  = 96;
    localparam int NC  = 5;
    localparam int NR  = 4;

    logic clk = 1'b0;
    logic rst_n;

    touch_tap_decoder_if bus();

    touch_tap_decoder #(
        .DEBOUNCE_CYCLES (D),
        .RELEASE_CYCLES  (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 armed, 1 press accepted and being located, 2 held
    int mMode     = 0;
    int mHigh     = 0;
    int mLow      = 0;
    int mEdge     = 0;
    int mEmitAt   = 0;
    int mPendHole = 0;
    bit mPendIn   = 1'b0;
    bit eTapValid = 1'b0;
    bit eInGrid   = 1'b0;
    bit eHeld     = 1'b0;
    int eHole     = 0;

    // Cell by plain division; latency counts the locator's step cycles
    task automatic modelLocate(input int x, input int y, output bit inG,
                               output int hole, output int lat);
        int col;
        int row;
        if (x < GX0 || y < GY0) begin
            inG  = 1'b0;
            hole = 0;
            lat  = 1;
        end else begin
            col = (x - GX0) / CW;
            if (col > NC) col = NC;
            row = (y - GY0) / CH;
            if (row > NR) row = NR;
            inG  = (col < NC) && (row < NR);
            hole = inG ? row * NC + col : 0;
            lat  = ((col > row) ? col : row) + 2;
        end
    endtask

    task automatic modelStep(input bit r, input bit e, input bit t, input int x, input int y);
        int lat;
        mEdge++;
        eTapValid = 1'b0;
        if (!r) begin
            mMode = 0; mHigh = 0; mLow = 0;
            eInGrid = 1'b0; eHole = 0; eHeld = 1'b0;
        end else if (!e) begin
            mMode = 0; mHigh = 0; eHeld = 1'b0;
        end else begin
            case (mMode)
                0: begin
                    mHigh = t ? mHigh + 1 : 0;
                    if (mHigh == D + 1) begin
                        modelLocate(x, y, mPendIn, mPendHole, lat);
                        mEmitAt = mEdge + lat;
                        mMode   = 1;
                        mHigh   = 0;
                    end
                end
                1: begin
                    if (mEdge == mEmitAt) begin
                        eTapValid = 1'b1;
                        eInGrid   = mPendIn;
                        eHole     = mPendHole;
                        eHeld     = 1'b1;
                        mMode     = 2;
                        mLow      = 0;
                    end
                end
                default: begin
                    if (mEdge > mEmitAt + 1) begin
                        mLow = t ? 0 : mLow + 1;
                        if (mLow == R) begin
                            mMode = 0; mHigh = 0; eHeld = 1'b0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic checkOutput();
        int expOne;
        expOne = (eTapValid && eInGrid) ? (1 << eHole) : 0;
        total++;
        if (bus.tap_valid !== eTapValid || bus.tap_in_grid !== eInGrid ||
            bus.tap_hole !== 5'(eHole) || bus.tap_onehot !== 20'(expOne) ||
            bus.touch_held !== eHeld) begin
            bad++;
            $display("[TB] FAIL model edge=%0d: got v=%b g=%b h=%0d oh=%h held=%b, want v=%b g=%b h=%0d oh=%h held=%b",
                     mEdge, bus.tap_valid, bus.tap_in_grid, bus.tap_hole, bus.tap_onehot, bus.touch_held,
                     eTapValid, eInGrid, eHole, expOne, eHeld);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // One clock: drive at the falling edge, clock, sample at the next fall
    task automatic applyStimulus(input bit r, input bit e, input bit t, input int x, input int y);
        rst_n           = r;
        bus.en          = e;
        bus.touch_valid = t;
        bus.tp_x_coord  = 16'(x);
        bus.tp_y_coord  = 16'(y);
        @(posedge clk);
        modelStep(r, e, t, x, y);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic pressFor(input int x, input int y, input int cycles,
                            output int firstEdge, output int pulses,
                            output int hole, output int inG, output int oneHot);
        firstEdge = -1; pulses = 0; hole = -1; inG = -1; oneHot = -1;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, x, y);
            if (bus.tap_valid === 1'b1) begin
                pulses++;
                if (firstEdge < 0) begin
                    firstEdge = i;
                    hole      = int'(bus.tap_hole);
                    inG       = int'(bus.tap_in_grid);
                    oneHot    = int'(bus.tap_onehot);
                end
            end
        end
    endtask

    task automatic releaseFor(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    typedef struct {
        int x;
        int y;
        int expEdge;
        int expHole;
        int expInGrid;
    } tapVec_t;

    tapVec_t vecs[8];

    initial begin
        int fe, np, h, g, oh, np2;
        int x, y, runLeft;
        bit tv, e, r;

        // pulse edge = D + max(col,row) + 2, or D + 1 when left/above the grid
        vecs[0] = '{346,   413,   9,  17, 1};
        vecs[1] = '{50,    200,   5,  0,  0};
        vecs[2] = '{720,   200,   11, 0,  0};
        vecs[3] = '{80,    120,   6,  0,  1};
        vecs[4] = '{207,   215,   6,  0,  1};
        vecs[5] = '{208,   216,   7,  6,  1};
        vecs[6] = '{719,   503,   10, 19, 1};
        vecs[7] = '{65535, 65535, 11, 0,  0};

        rst_n = 1'b0; bus.en = 1'b0; bus.touch_valid = 1'b0;
        bus.tp_x_coord = '0; bus.tp_y_coord = '0;
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 346, 413);
        checkValue("rst_tap_valid", int'(bus.tap_valid), 0);
        checkValue("rst_in_grid", int'(bus.tap_in_grid), 0);
        checkValue("rst_hole", int'(bus.tap_hole), 0);
        checkValue("rst_onehot", int'(bus.tap_onehot), 0);
        checkValue("rst_held", int'(bus.touch_held), 0);
        releaseFor(1);

        $display("[TB] directed tap table");
        for (int i = 0; i < 8; i++) begin
            pressFor(vecs[i].x, vecs[i].y, 20, fe, np, h, g, oh);
            checkValue($sformatf("v%0d_edge", i), fe, vecs[i].expEdge);
            checkValue($sformatf("v%0d_pulses", i), np, 1);
            checkValue($sformatf("v%0d_hole", i), h, vecs[i].expHole);
            checkValue($sformatf("v%0d_in_grid", i), g, vecs[i].expInGrid);
            checkValue($sformatf("v%0d_onehot", i), oh,
                       (vecs[i].expInGrid != 0) ? (1 << vecs[i].expHole) : 0);
            checkValue($sformatf("v%0d_held_on", i), int'(bus.touch_held), 1);
            releaseFor(R - 1);
            checkValue($sformatf("v%0d_held_r2", i), int'(bus.touch_held), 1);
            releaseFor(1);
            checkValue($sformatf("v%0d_held_off", i), int'(bus.touch_held), 0);
        end

        $display("[TB] glitch filter");
        pressFor(80, 120, 3, fe, np, h, g, oh);
        releaseFor(1);
        pressFor(80, 120, 3, fe, np2, h, g, oh);
        checkValue("glitch_pulses", np + np2, 0);
        pressFor(80, 120, 12, fe, np, h, g, oh);
        checkValue("glitch_cont_pulses", np, 1);
        checkValue("glitch_cont_edge", fe, 3);
        releaseFor(R);

        $display("[TB] re-arm");
        pressFor(346, 413, 15, fe, np, h, g, oh);
        checkValue("rearm_first", np, 1);
        releaseFor(R - 1);
        pressFor(346, 413, 15, fe, np, h, g, oh);
        checkValue("rearm_short_release", np, 0);
        checkValue("rearm_still_held", int'(bus.touch_held), 1);
        releaseFor(R);
        checkValue("rearm_released", int'(bus.touch_held), 0);
        pressFor(208, 216, 15, fe, np, h, g, oh);
        checkValue("rearm_second", np, 1);
        checkValue("rearm_second_hole", h, 6);
        releaseFor(R);

        $display("[TB] en drop during locate");
        pressFor(346, 413, 6, fe, np, h, g, oh);
        np2 = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 346, 413);
            if (bus.tap_valid === 1'b1) np2++;
        end
        checkValue("en_pulses", np + np2, 0);
        checkValue("en_held", int'(bus.touch_held), 0);
        checkValue("en_hole_kept", int'(bus.tap_hole), 6);
        checkValue("en_in_grid_kept", int'(bus.tap_in_grid), 1);
        releaseFor(1);
        pressFor(207, 215, 12, fe, np, h, g, oh);
        checkValue("en_after_edge", fe, 6);
        checkValue("en_after_hole", h, 0);
        releaseFor(R);

        $display("[TB] reset while held");
        pressFor(208, 216, 12, fe, np, h, g, oh);
        checkValue("rh_pulse", np, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 208, 216);
        checkValue("rh_tap_valid", int'(bus.tap_valid), 0);
        checkValue("rh_held", int'(bus.touch_held), 0);
        checkValue("rh_hole", int'(bus.tap_hole), 0);
        checkValue("rh_in_grid", int'(bus.tap_in_grid), 0);
        releaseFor(1);
        pressFor(346, 413, 15, fe, np, h, g, oh);
        checkValue("rh_new_edge", fe, 9);
        checkValue("rh_new_hole", h, 17);
        checkValue("rh_new_pulses", np, 1);
        releaseFor(R);

        $display("[TB] randomized streams");
        tv = 1'b0; runLeft = 0; x = 300; y = 300;
        for (int i = 0; i < 3000; i++) begin
            if (runLeft == 0) begin
                tv      = !tv;
                runLeft = tv ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 5));
                x       = int'($urandom_range(0, 800));
                y       = int'($urandom_range(60, 620));
            end
            runLeft--;
            if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 800));
            if ($urandom_range(0, 99) == 0) x = 65535;
            e = ($urandom_range(0, 49) != 0);
            r = ($urandom_range(0, 199) != 0);
            applyStimulus(r, e, tv, x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
